// File: rtl/mux_4_1_pkg.sv
// Shared constants for the registered 4:1 multiplexer: select codes and default data width.
package mux_4_1_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  localparam logic [1:0] SEL_A = 2'b00;
  localparam logic [1:0] SEL_B = 2'b01;
  localparam logic [1:0] SEL_C = 2'b10;
  localparam logic [1:0] SEL_D = 2'b11;

endpackage

// File: rtl/mux_4_1_sel.sv
// Purely combinational 4:1 word selector; S picks one of A..D.
module mux_4_1_sel
  import mux_4_1_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic [1:0]       S,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] sel
);

  always_comb begin
    sel = A;
    unique case (S)
      SEL_A: sel = A;
      SEL_B: sel = B;
      SEL_C: sel = C;
      SEL_D: sel = D;
    endcase
  end

endmodule

// File: rtl/mux_4_1.sv
// Registered 4:1 multiplexer with valid qualifier; optional even-parity output
// F_par when MUX_4_1_PARITY_EN is defined.
module mux_4_1
  import mux_4_1_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [WIDTH-1:0] F,
  input  logic [1:0]       S,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C,
  input  logic [WIDTH-1:0] D,
  input  logic             in_valid,
  output logic             out_valid
`ifdef MUX_4_1_PARITY_EN
  ,
  output logic             F_par
`endif
);

  logic [WIDTH-1:0] sel;
  logic [WIDTH-1:0] f_q;
  logic             out_valid_q;

  mux_4_1_sel #(
    .WIDTH(WIDTH)
  ) u_sel (
    .S  (S),
    .A  (A),
    .B  (B),
    .C  (C),
    .D  (D),
    .sel(sel)
  );

  // Data holds across invalid cycles; the valid flag tracks in_valid every edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      f_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= in_valid;
      if (in_valid) begin
        f_q <= sel;
      end
    end
  end

  assign F         = f_q;
  assign out_valid = out_valid_q;

`ifdef MUX_4_1_PARITY_EN
  logic f_par_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      f_par_q <= 1'b0;
    end else if (in_valid) begin
      f_par_q <= ^sel;
    end
  end

  assign F_par = f_par_q;
`endif

endmodule

// File: tb/tb_mux_4_1.sv
// Self-checking bench for mux_4_1: directed cases with literal expectations plus
// randomized traffic compared every cycle against a behavioural model.
module tb_mux_4_1;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] F;
  logic [1:0]   S;
  logic [W-1:0] A, B, C, D;
  logic         in_valid;
  logic         out_valid;
`ifdef MUX_4_1_PARITY_EN
  logic         F_par;
`endif

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  mux_4_1 #(
    .WIDTH(W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .F        (F),
    .S        (S),
    .A        (A),
    .B        (B),
    .C        (C),
    .D        (D),
    .in_valid (in_valid),
    .out_valid(out_valid)
`ifdef MUX_4_1_PARITY_EN
    ,
    .F_par    (F_par)
`endif
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Behavioural model: pick the candidate indexed by S, hold when not valid.
  logic [W-1:0] exp_f;
  logic         exp_v;
  bit           live = 0;

  always @(posedge clk) begin
    logic [W-1:0] cand [4];
    cand = '{A, B, C, D};
    if (!rst_n) begin
      exp_f = '0;
      exp_v = 1'b0;
    end else begin
      exp_v = in_valid;
      if (in_valid) exp_f = cand[S];
    end
    live = 1;
  end

  always @(negedge clk) begin
    if (live) begin
      chk("model_F", 32'(F), 32'(exp_f));
      chk("model_out_valid", 32'(out_valid), 32'(exp_v));
`ifdef MUX_4_1_PARITY_EN
      chk("model_F_par", 32'(F_par), 32'(^exp_f));
`endif
    end
  end

  // Apply inputs, then advance past the next rising edge.
  task automatic cycle(input logic r, input logic v, input logic [1:0] s,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] c, input logic [W-1:0] d);
    rst_n    = r;
    in_valid = v;
    S        = s;
    A        = a;
    B        = b;
    C        = c;
    D        = d;
    @(posedge clk);
    #2;
  endtask

  initial begin
    // Reset wins over a valid input.
    cycle(1'b0, 1'b1, 2'b11, 8'h11, 8'h22, 8'h33, 8'h4B);
    chk("reset_F", 32'(F), 32'h00);
    chk("reset_out_valid", 32'(out_valid), 32'h0);
`ifdef MUX_4_1_PARITY_EN
    chk("reset_F_par", 32'(F_par), 32'h0);
`endif

    cycle(1'b1, 1'b1, 2'b00, 8'h08, 8'h41, 8'h03, 8'h4B);
    chk("selA_F", 32'(F), 32'h08);
    chk("selA_out_valid", 32'(out_valid), 32'h1);
`ifdef MUX_4_1_PARITY_EN
    chk("selA_F_par", 32'(F_par), 32'h1);
`endif

    // Back-to-back select steps.
    cycle(1'b1, 1'b1, 2'b01, 8'h00, 8'h01, 8'h02, 8'h03);
    chk("step01_F", 32'(F), 32'h01);
    cycle(1'b1, 1'b1, 2'b10, 8'h00, 8'h01, 8'h02, 8'h03);
    chk("step10_F", 32'(F), 32'h02);
    cycle(1'b1, 1'b1, 2'b11, 8'h00, 8'h01, 8'h02, 8'h03);
    chk("step11_F", 32'(F), 32'h03);
    cycle(1'b1, 1'b1, 2'b00, 8'h00, 8'h01, 8'h02, 8'h03);
    chk("step00_F", 32'(F), 32'h00);
    cycle(1'b1, 1'b1, 2'b11, 8'h00, 8'h01, 8'h02, 8'h03);
    chk("recap_F", 32'(F), 32'h03);

    // Hold while invalid, even as inputs move.
    cycle(1'b1, 1'b0, 2'b01, 8'hAA, 8'hBB, 8'hCC, 8'hDD);
    chk("hold1_F", 32'(F), 32'h03);
    chk("hold1_out_valid", 32'(out_valid), 32'h0);
    cycle(1'b1, 1'b0, 2'b10, 8'h5A, 8'hA5, 8'hFF, 8'h7E);
    chk("hold2_F", 32'(F), 32'h03);

    // Mid-stream reset, then resume on release.
    cycle(1'b0, 1'b1, 2'b10, 8'h10, 8'h20, 8'h30, 8'h40);
    chk("midrst_F", 32'(F), 32'h00);
    chk("midrst_out_valid", 32'(out_valid), 32'h0);
    cycle(1'b1, 1'b1, 2'b01, 8'h08, 8'h41, 8'h03, 8'h4B);
    chk("resume_F", 32'(F), 32'h41);
    chk("resume_out_valid", 32'(out_valid), 32'h1);
    cycle(1'b1, 1'b1, 2'b11, 8'h00, 8'h00, 8'h00, 8'hFF);
    chk("allbits_F", 32'(F), 32'hFF);

    // Randomized traffic, checked by the model process.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(15) != 0), 1'($urandom), 2'($urandom),
            W'($urandom), W'($urandom), W'($urandom), W'($urandom));
    end

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
